// File: rtl/execute_stage_pipelined.sv
// Registered RISC-V EX stage: operand forwarding, ALU decode, branch-target
// adder, optional iterative M-extension unit, and an EX/MEM output register
// behind a valid/ready handshake.
module execute_stage_pipelined #(
  parameter int WIDTH     = 32,
  parameter bit ENABLE_MD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [1:0]       alu_op,
  input  logic             alu_src,
  input  logic             funct7_5,
  input  logic             funct7_0,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] fwd_mem,
  input  logic [WIDTH-1:0] fwd_wb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] store_data,
  output logic [WIDTH-1:0] branch_target,
  output logic             zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

  md_state_t          state, state_next;
  logic [SW-1:0]      count;
  logic [2:0]         md_f3;
  logic               md_neg, md_div0;
  logic [WIDTH-1:0]   md_a, md_b, acc_lo, md_store, md_target;
  logic [WIDTH:0]     acc_hi;

  logic [WIDTH-1:0]   op_a, b_reg, op_b, alu_res, md_res;
  logic [SW-1:0]      shamt;
  logic               md_op, fire, alu_load, md_start, md_load;
  logic               signed_a, signed_b, neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] product, product_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  // Forwarding muxes and B-operand select.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op_a  = rd1;
    b_reg = rd2;
    case (fwd_a_sel)
      2'b01:   op_a = fwd_mem;
      2'b10:   op_a = fwd_wb;
      default: op_a = rd1;
    endcase
    case (fwd_b_sel)
      2'b01:   b_reg = fwd_mem;
      2'b10:   b_reg = fwd_wb;
      default: b_reg = rd2;
    endcase
    op_b  = alu_src ? imm : b_reg;
    shamt = op_b[SW-1:0];
  end

  // Single-cycle ALU decode; funct7_5 means sub only for R-type, sra for both.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      default: begin
        case (funct3)
          3'b000:  alu_res = (alu_op == 2'b10 && funct7_5) ? op_a - op_b : op_a + op_b;
          3'b001:  alu_res = op_a << shamt;
          3'b010:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
          3'b011:  alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
          3'b100:  alu_res = op_a ^ op_b;
          3'b101:  alu_res = funct7_5 ? $unsigned($signed(op_a) >>> shamt) : op_a >> shamt;
          3'b110:  alu_res = op_a | op_b;
          default: alu_res = op_a & op_b;
        endcase
      end
    endcase
  end

  // Handshake: the stage refuses work while the MD unit owns it or the output is stuck.
  always_comb begin
    md_op    = ENABLE_MD && (alu_op == 2'b10) && funct7_0;
    busy     = (state != MD_IDLE);
    in_ready = ~busy & (~out_valid | out_ready);
    fire     = in_valid & in_ready & ~flush;
    alu_load = fire & ~md_op;
    md_start = fire & md_op;
    md_load  = (state == MD_DONE) & ~flush & (~out_valid | out_ready);
  end

  // Operand magnitudes and result sign captured when an MD op fires.
  always_comb begin
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    neg_a    = signed_a & op_a[WIDTH-1];
    neg_b    = signed_b & op_b[WIDTH-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  always_comb begin
    mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, md_b} : '0);
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, md_b};
  end

  // Sign correction and divide-by-zero override applied in DONE.
  always_comb begin
    product   = {acc_hi[WIDTH-1:0], acc_lo};
    product_s = md_neg ? -product : product;
    quo_s     = md_neg ? -acc_lo : acc_lo;
    rem_s     = md_neg ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    md_res    = '0;
    if (!md_f3[2])
      md_res = (md_f3[1:0] == 2'b00) ? product_s[WIDTH-1:0] : product_s[2*WIDTH-1:WIDTH];
    else if (md_div0)
      md_res = md_f3[1] ? md_a : '1;
    else
      md_res = md_f3[1] ? rem_s : quo_s;
  end

  // MD FSM next state: flush aborts RUN/DONE; DONE waits for room in the output register.
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (md_start) state_next = MD_RUN;
      MD_RUN:  if (flush) state_next = MD_IDLE;
               else if (count == SW'(WIDTH - 1)) state_next = MD_DONE;
      MD_DONE: if (flush || md_load) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // MD state register, iteration counter and working registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= MD_IDLE;
      count     <= '0;
      md_f3     <= '0;
      md_neg    <= 1'b0;
      md_div0   <= 1'b0;
      md_a      <= '0;
      md_b      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      md_store  <= '0;
      md_target <= '0;
    end else begin
      state <= state_next;
      if (md_start) begin
        count     <= '0;
        md_f3     <= funct3;
        md_neg    <= (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);
        md_div0   <= (op_b == '0);
        md_a      <= op_a;
        md_b      <= mag_b;
        acc_hi    <= '0;
        acc_lo    <= mag_a;
        md_store  <= b_reg;
        md_target <= pc + {imm[WIDTH-2:0], 1'b0};
      end else if (state == MD_RUN) begin
        count <= count + 1'b1;
        if (md_f3[2]) begin
          if (!div_diff[WIDTH+1]) begin
            acc_hi <= div_diff[WIDTH:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift;
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_hi <= {1'b0, mul_sum[WIDTH:1]};
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
      end
    end
  end

  // EX/MEM output register: load on ALU fire or MD DONE, hold while stalled, drain otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      alu_out       <= '0;
      store_data    <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
    end else if (alu_load) begin
      out_valid     <= 1'b1;
      alu_out       <= alu_res;
      store_data    <= b_reg;
      branch_target <= pc + {imm[WIDTH-2:0], 1'b0};
      zero          <= (alu_res == '0);
    end else if (md_load) begin
      out_valid     <= 1'b1;
      alu_out       <= md_res;
      store_data    <= md_store;
      branch_target <= md_target;
      zero          <= (md_res == '0);
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage_pipelined.sv
// Self-checking bench for execute_stage_pipelined (WIDTH=32, ENABLE_MD=1):
// a transaction-level model predicts the output register, and directed
// vectors carry hand-computed literal expectations.
module tb_execute_stage_pipelined;

  localparam int WIDTH   = 32;
  localparam int MD_LAT  = WIDTH;

  logic        clk, rst, in_valid, in_ready, flush;
  logic [1:0]  alu_op;
  logic        alu_src, funct7_5, funct7_0;
  logic [2:0]  funct3;
  logic [31:0] rd1, rd2, imm, pc;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] fwd_mem, fwd_wb;
  logic        out_valid, out_ready;
  logic [31:0] alu_out, store_data, branch_target;
  logic        zero, busy;

  int n_vec = 0;
  int n_bad = 0;

  execute_stage_pipelined #(.WIDTH(WIDTH), .ENABLE_MD(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .alu_op(alu_op), .alu_src(alu_src), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .funct3(funct3), .rd1(rd1), .rd2(rd2), .imm(imm), .pc(pc),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .store_data(store_data), .branch_target(branch_target), .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of one instruction, from RISC-V semantics with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic f75, input logic f70,
                                             input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    if (op == 2'b10 && f70) begin
      case (f3)
        3'd0: r = a * b;
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * longint'({32'h0, b}); r = p[63:32]; end
        3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
        3'd4: r = (b == '0) ? 32'hFFFF_FFFF : 32'(sa / sb);
        3'd5: r = (b == '0) ? 32'hFFFF_FFFF : a / b;
        3'd6: r = (b == '0) ? a : 32'(sa % sb);
        default: r = (b == '0) ? a : a % b;
      endcase
    end else if (op == 2'b00) r = a + b;
    else if (op == 2'b01) r = a - b;
    else begin
      case (f3)
        3'd0: r = (op == 2'b10 && f75) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = f75 ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return fwd_mem;
    if (sel == 2'b10) return fwd_wb;
    return rf;
  endfunction

  // Transaction model: expected output register plus one pending MD result with a countdown.
  logic        m_valid, m_zero, m_busy, m_fire, m_ld;
  logic [31:0] m_alu, m_sd, m_bt;
  logic [31:0] m_a, m_bv, m_b, m_res, m_ld_res, m_ld_sd, m_ld_bt;
  logic [31:0] m_md_res, m_md_sd, m_md_bt;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0; m_alu = '0; m_sd = '0; m_bt = '0; m_zero = 1'b0;
      m_busy = 1'b0; m_fire = 1'b0; m_left = 0;
    end else begin
      m_fire = in_valid && !m_busy && (!m_valid || out_ready) && !flush;
      m_ld   = 1'b0;
      if (m_busy) begin
        if (flush) m_busy = 1'b0;
        else if (m_left > 0) m_left--;
        else if (!m_valid || out_ready) begin
          m_ld = 1'b1; m_ld_res = m_md_res; m_ld_sd = m_md_sd; m_ld_bt = m_md_bt;
          m_busy = 1'b0;
        end
      end
      if (m_fire) begin
        m_a   = pick(fwd_a_sel, rd1);
        m_bv  = pick(fwd_b_sel, rd2);
        m_b   = alu_src ? imm : m_bv;
        m_res = ref_result(alu_op, funct7_5, funct7_0, funct3, m_a, m_b);
        if (alu_op == 2'b10 && funct7_0) begin
          m_busy = 1'b1; m_left = MD_LAT;
          m_md_res = m_res; m_md_sd = m_bv; m_md_bt = pc + (imm << 1);
        end else begin
          m_ld = 1'b1; m_ld_res = m_res; m_ld_sd = m_bv; m_ld_bt = pc + (imm << 1);
        end
      end
      if (m_ld) begin
        m_valid = 1'b1; m_alu = m_ld_res; m_sd = m_ld_sd; m_bt = m_ld_bt;
        m_zero = (m_ld_res == '0);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare the DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check_bit("out_valid", out_valid, m_valid);
      check_bit("in_ready", in_ready, !m_busy && (!m_valid || out_ready));
      check_bit("busy", busy, m_busy);
      if (m_valid) begin
        check("alu_out", alu_out, m_alu);
        check("store_data", store_data, m_sd);
        check("branch_target", branch_target, m_bt);
        check_bit("zero", zero, m_zero);
      end
    end
  end

  // Present one instruction and hold it until accepted, then scramble the operand buses.
  task automatic issue(input logic [1:0] op, input logic src, input logic f75, input logic f70,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p);
    alu_op = op; alu_src = src; funct7_5 = f75; funct7_0 = f70; funct3 = f3;
    rd1 = a; rd2 = b; imm = im; pc = p; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (m_fire) begin
        in_valid = 1'b0;
        rd1 = $urandom; rd2 = $urandom; imm = $urandom; pc = $urandom;
        fwd_mem = $urandom; fwd_wb = $urandom;
        return;
      end
    end
    check_bit("issue_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic alu_lit(input string name, input logic [31:0] exp);
    @(negedge clk);
    check(name, alu_out, exp);
  endtask

  task automatic md_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    issue(2'b10, 1'b0, 1'b0, 1'b1, f3, a, b, 32'h0, 32'h0);
    repeat (MD_LAT + 2) @(negedge clk);
    check_bit({name, "_valid"}, out_valid, 1'b1);
    check(name, alu_out, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; alu_op = '0; alu_src = 1'b0;
    funct7_5 = 1'b0; funct7_0 = 1'b0; funct3 = '0; rd1 = '0; rd2 = '0; imm = '0; pc = '0;
    fwd_a_sel = '0; fwd_b_sel = '0; fwd_mem = '0; fwd_wb = '0; out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_zero", zero, 1'b0);
    check("rst_alu_out", alu_out, 32'h0);
    check("rst_store_data", store_data, 32'h0);
    check("rst_branch_target", branch_target, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: add immediate.
    issue(2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'hDEAD, 32'd7, 32'h0);
    @(negedge clk);
    check_bit("t1_valid", out_valid, 1'b1);
    check("t1_alu", alu_out, 32'd12);
    check_bit("t1_zero", zero, 1'b0);

    // 2: branch compare with MEM forwarding on A.
    fwd_a_sel = 2'b01; fwd_mem = 32'd9;
    issue(2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 32'd123, 32'd9, 32'd4, 32'h100);
    fwd_a_sel = 2'b00;
    @(negedge clk);
    check("t2_alu", alu_out, 32'h0);
    check_bit("t2_zero", zero, 1'b1);
    check("t2_target", branch_target, 32'h108);

    // ALU decode coverage.
    issue(2'b10, 1'b0, 1'b1, 1'b0, 3'b000, 32'd5, 32'd9, 32'h0, 32'h0);
    alu_lit("r_sub", 32'hFFFF_FFFC);
    issue(2'b11, 1'b1, 1'b1, 1'b0, 3'b000, 32'd10, 32'h0, 32'd3, 32'h0);
    alu_lit("i_add_f75", 32'd13);
    issue(2'b11, 1'b1, 1'b0, 1'b0, 3'b001, 32'd1, 32'h0, 32'h23, 32'h0);
    alu_lit("i_sll_mask", 32'd8);
    issue(2'b10, 1'b0, 1'b0, 1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    alu_lit("r_slt", 32'd1);
    issue(2'b10, 1'b0, 1'b0, 1'b0, 3'b011, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    alu_lit("r_sltu", 32'd0);
    issue(2'b11, 1'b1, 1'b0, 1'b0, 3'b100, 32'h0000_F0F0, 32'h0, 32'h0000_00FF, 32'h0);
    alu_lit("i_xor", 32'h0000_F00F);
    issue(2'b11, 1'b1, 1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0, 32'd4, 32'h0);
    alu_lit("i_sra", 32'hF800_0000);
    issue(2'b10, 1'b0, 1'b0, 1'b0, 3'b101, 32'h8000_0000, 32'd4, 32'h0, 32'h0);
    alu_lit("r_srl", 32'h0800_0000);
    fwd_a_sel = 2'b11; fwd_b_sel = 2'b10; fwd_wb = 32'h0000_00F0;
    issue(2'b10, 1'b0, 1'b0, 1'b0, 3'b110, 32'h0000_000F, 32'h1234_5678, 32'h0, 32'h0);
    fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
    alu_lit("r_or_fwdwb", 32'h0000_00FF);
    issue(2'b10, 1'b0, 1'b0, 1'b0, 3'b111, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 32'h0);
    alu_lit("r_and", 32'h0F00_0F00);
    issue(2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 32'd1, 32'hFFFF_FFF0);
    @(negedge clk);
    check("add_wrap", alu_out, 32'h0);
    check("target_wrap", branch_target, 32'hFFFF_FFF2);

    // 3: multi-cycle multiply with exact latency.
    issue(2'b10, 1'b0, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
    for (int k = 1; k <= MD_LAT + 2; k++) begin
      @(negedge clk);
      if (k <= MD_LAT) check_bit("mul_busy", busy, 1'b1);
      if (k <= MD_LAT + 1) begin
        check_bit("mul_in_ready", in_ready, 1'b0);
        check_bit("mul_early_valid", out_valid, 1'b0);
      end else begin
        check_bit("mul_valid", out_valid, 1'b1);
        check("mul_result", alu_out, 32'hFFFF_FFFE);
        check_bit("mul_busy_done", busy, 1'b0);
      end
    end

    // 4: division corner cases and remaining MD encodings.
    md_check("div_by_zero", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF);
    md_check("rem_by_zero", 3'b110, 32'd7, 32'd0, 32'd7);
    md_check("div_overflow", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_check("rem_overflow", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    md_check("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md_check("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    md_check("divu_zero", 3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF);
    md_check("remu", 3'b111, 32'd100, 32'd7, 32'd2);
    md_check("mulh", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF);
    md_check("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_check("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // 5: output stall then back-to-back drain and load.
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    issue(2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'd1, 32'd2, 32'h0, 32'h0);
    alu_op = 2'b00; alu_src = 1'b0; funct7_0 = 1'b0; rd1 = 32'd20; rd2 = 32'd10; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_alu", alu_out, 32'd3);
      check_bit("stall_valid", out_valid, 1'b1);
      check_bit("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check_bit("drain_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check_bit("b2b_fire", m_fire, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_bit("b2b_valid", out_valid, 1'b1);
    check("b2b_alu", alu_out, 32'd30);

    // flush blocks a fire in the same cycle.
    @(posedge clk); #1;
    alu_op = 2'b00; rd1 = 32'd1; rd2 = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_bit("flush_block_valid", out_valid, 1'b0);

    // 6: flush at RUN cycle 10.
    issue(2'b10, 1'b0, 1'b0, 1'b1, 3'b000, 32'd3, 32'd4, 32'h0, 32'h0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check_bit("flush_busy", busy, 1'b0);
    check_bit("flush_valid", out_valid, 1'b0);
    repeat (MD_LAT + 4) @(negedge clk);
    issue(2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 32'd40, 32'h0, 32'd2, 32'h0);
    alu_lit("after_flush", 32'd42);

    // Reset in the middle of RUN.
    issue(2'b10, 1'b0, 1'b0, 1'b1, 3'b101, 32'd100, 32'd7, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_valid", out_valid, 1'b0);
    check_bit("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (MD_LAT + 6) @(negedge clk);
    issue(2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 32'd100, 32'd23, 32'h0, 32'h0);
    alu_lit("after_reset", 32'd123);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
